// File: rtl/sobel_stream_ctrl.sv
// ---------------------------------------------------------------------------
// sobel_stream_ctrl
//
// Frame-geometry driven sequencer for the Sobel edge pipeline. Walks a frame
// held in pixel SRAM one word at a time, issues the SRAM read for each word,
// produces the per-word phase strobes for the buffer / shifter / hold /
// multiplier / magnitude stages, generates result write strobes and
// addresses, and raises a one-shot prefetch request to the frame loader near
// the end of the frame. Owns no pixel data.
//
// Ports
//   clk, reset      : clock, synchronous active-high reset
//   start           : frame start request, level-sampled in IDLE only
//   rd_base/wr_base : input/output frame base addresses, captured on start
//   busy            : high while walking the frame or draining the pipeline
//   done            : one-cycle end-of-frame pulse
//   rd_en/rd_addr   : SRAM read strobe and word address (address holds
//                     between reads)
//   pop_en, shift_en, hold_en, mult_en, mag_en : datapath phase strobes
//   wr_en/wr_addr   : result write strobe and address (address advances the
//                     cycle after each write)
//   get_next        : one-cycle prefetch request, at most once per frame
// ---------------------------------------------------------------------------
module sobel_stream_ctrl #(
    parameter int IMG_W          = 512,
    parameter int IMG_H          = 512,
    parameter int LANES          = 8,
    parameter int ADDR_W         = 20,
    parameter int PHASES         = 8,
    parameter int PIPE_LAT       = 4,
    parameter int PREFETCH_LINES = 2,
    parameter int SKIP_MODE      = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] rd_base,
    input  logic [ADDR_W-1:0] wr_base,
    output logic              busy,
    output logic              done,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              pop_en,
    output logic              shift_en,
    output logic              hold_en,
    output logic              mult_en,
    output logic              mag_en,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              get_next
);

    // Frame geometry
    localparam int WPL      = IMG_W / LANES;
    localparam int STEP     = (SKIP_MODE != 0) ? 2 : 1;
    localparam int ROWS     = IMG_H / STEP;
    localparam int PRIME    = 2 * WPL;
    localparam int NWORDS   = WPL * ROWS;
    localparam int GN_ROW_I = (IMG_H > PREFETCH_LINES) ? (IMG_H - PREFETCH_LINES) : 0;
    localparam int DRAIN_I  = (PIPE_LAT > 0) ? (PIPE_LAT - 1) : 0;

    // Counter widths
    localparam int PH_W     = $clog2(PHASES);
    localparam int COL_W    = (WPL > 1) ? $clog2(WPL) : 1;
    localparam int ROW_W    = $clog2(IMG_H + STEP + 1);
    localparam int WIDX_MAX = (NWORDS > PRIME) ? NWORDS : PRIME;
    localparam int WIDX_W   = $clog2(WIDX_MAX + 1);
    localparam int DRAIN_W  = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

    // Phase slots within a word
    localparam logic [PH_W-1:0] PH_RD    = PH_W'(0);
    localparam logic [PH_W-1:0] PH_POP   = PH_W'(2);
    localparam logic [PH_W-1:0] PH_SHIFT = PH_W'(3);
    localparam logic [PH_W-1:0] PH_HOLD  = PH_W'(4);
    localparam logic [PH_W-1:0] PH_MAG   = PH_W'(5);
    localparam logic [PH_W-1:0] PH_WR    = PH_W'(6);
    localparam logic [PH_W-1:0] PH_LAST  = PH_W'(PHASES - 1);

    localparam logic [COL_W-1:0]   COL_LAST   = COL_W'(WPL - 1);
    localparam logic [ROW_W-1:0]   ROW_STEP   = ROW_W'(STEP);
    localparam logic [ROW_W-1:0]   GN_ROW     = ROW_W'(GN_ROW_I);
    localparam logic [WIDX_W-1:0]  WIDX_LAST  = WIDX_W'(NWORDS - 1);
    localparam logic [WIDX_W-1:0]  WIDX_PRIME = WIDX_W'(PRIME);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_I);

    // Address step when leaving the last word of a line: the next word of
    // the line, plus a whole skipped line when every second line is used.
    localparam logic [ADDR_W-1:0] ADDR_ONE      = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] ADDR_ROW_JUMP = ADDR_W'(1 + (STEP - 1) * WPL);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t              state_reg,   state_next;
    logic [PH_W-1:0]     ph_reg,      ph_next;
    logic [COL_W-1:0]    col_reg,     col_next;
    logic [ROW_W-1:0]    row_reg,     row_next;
    logic [WIDX_W-1:0]   widx_reg,    widx_next;
    logic [DRAIN_W-1:0]  drain_reg,   drain_next;
    logic [ADDR_W-1:0]   rd_addr_reg, rd_addr_next;
    logic [ADDR_W-1:0]   wr_addr_reg, wr_addr_next;
    logic                gn_done_reg, gn_done_next;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg   <= S_IDLE;
            ph_reg      <= '0;
            col_reg     <= '0;
            row_reg     <= '0;
            widx_reg    <= '0;
            drain_reg   <= '0;
            rd_addr_reg <= '0;
            wr_addr_reg <= '0;
            gn_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ph_reg      <= ph_next;
            col_reg     <= col_next;
            row_reg     <= row_next;
            widx_reg    <= widx_next;
            drain_reg   <= drain_next;
            rd_addr_reg <= rd_addr_next;
            wr_addr_reg <= wr_addr_next;
            gn_done_reg <= gn_done_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        ph_next      = ph_reg;
        col_next     = col_reg;
        row_next     = row_reg;
        widx_next    = widx_reg;
        drain_next   = drain_reg;
        rd_addr_next = rd_addr_reg;
        wr_addr_next = wr_addr_reg;
        gn_done_next = gn_done_reg;

        busy     = 1'b0;
        done     = 1'b0;
        rd_en    = 1'b0;
        pop_en   = 1'b0;
        shift_en = 1'b0;
        hold_en  = 1'b0;
        mult_en  = 1'b0;
        mag_en   = 1'b0;
        wr_en    = 1'b0;
        get_next = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    // The read address register doubles as the latched base:
                    // it already points at word 0 when RUN begins.
                    state_next   = S_RUN;
                    ph_next      = '0;
                    col_next     = '0;
                    row_next     = '0;
                    widx_next    = '0;
                    drain_next   = '0;
                    rd_addr_next = rd_base;
                    wr_addr_next = wr_base;
                    gn_done_next = 1'b0;
                end
            end

            S_RUN: begin
                busy     = 1'b1;
                rd_en    = (ph_reg == PH_RD);
                pop_en   = (ph_reg == PH_POP);
                shift_en = (ph_reg == PH_SHIFT);
                hold_en  = (ph_reg == PH_HOLD);
                mult_en  = (ph_reg == PH_HOLD);
                mag_en   = (ph_reg == PH_MAG);
                // The first two lines only prime the line buffers.
                wr_en    = (ph_reg == PH_WR) && (widx_reg >= WIDX_PRIME);
                // ">=" rather than "==" so that a target line skipped in
                // skip mode still fires on the next visited line.
                get_next = (ph_reg == PH_RD) && (col_reg == '0) &&
                           (row_reg >= GN_ROW) && !gn_done_reg;

                if (get_next) begin
                    gn_done_next = 1'b1;
                end
                if (wr_en) begin
                    wr_addr_next = wr_addr_reg + ADDR_ONE;
                end

                if (ph_reg == PH_LAST) begin
                    ph_next = '0;
                    if (widx_reg == WIDX_LAST) begin
                        state_next = (PIPE_LAT > 0) ? S_DRAIN : S_DONE;
                        drain_next = '0;
                    end else begin
                        widx_next = widx_reg + WIDX_W'(1);
                        if (col_reg == COL_LAST) begin
                            col_next     = '0;
                            row_next     = row_reg + ROW_STEP;
                            rd_addr_next = rd_addr_reg + ADDR_ROW_JUMP;
                        end else begin
                            col_next     = col_reg + COL_W'(1);
                            rd_addr_next = rd_addr_reg + ADDR_ONE;
                        end
                    end
                end else begin
                    ph_next = ph_reg + PH_W'(1);
                end
            end

            S_DRAIN: begin
                busy = 1'b1;
                if (drain_reg == DRAIN_LAST) begin
                    state_next = S_DONE;
                end else begin
                    drain_next = drain_reg + DRAIN_W'(1);
                end
            end

            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign rd_addr = rd_addr_reg;
    assign wr_addr = wr_addr_reg;

endmodule

// File: tb/tb_sobel_stream_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sobel_stream_ctrl
//
// Two controller instances share one clock and reset: g_dut[0] processes
// every line, g_dut[1] every second line. Geometry: 32x8 pixels, 8 lanes,
// 8 phases, 4 drain cycles, prefetch 2 lines ahead. Expected behaviour per
// cycle comes from the frame timing rules written as plain arithmetic on the
// cycle number relative to the start sample.
// ---------------------------------------------------------------------------
module tb_sobel_stream_ctrl;

    localparam int IMG_W = 32;
    localparam int IMG_H = 8;
    localparam int LANES = 8;
    localparam int WPL   = IMG_W / LANES;
    localparam int PH    = 8;
    localparam int PL    = 4;
    localparam int PF    = 2;
    localparam int PRIME = 2 * WPL;

    logic clk;
    logic reset;
    logic [1:0] start, busy, done, rd_en, pop_en, shift_en, hold_en, mult_en, mag_en, wr_en, get_next;
    logic [1:0][19:0] rd_base, wr_base, rd_addr, wr_addr;

    int total;
    int bad;

    for (genvar gi = 0; gi < 2; gi++) begin : g_dut
        sobel_stream_ctrl #(
            .IMG_W(IMG_W), .IMG_H(IMG_H), .LANES(LANES), .ADDR_W(20),
            .PHASES(PH), .PIPE_LAT(PL), .PREFETCH_LINES(PF), .SKIP_MODE(gi)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start[gi]),
            .rd_base(rd_base[gi]), .wr_base(wr_base[gi]),
            .busy(busy[gi]), .done(done[gi]),
            .rd_en(rd_en[gi]), .rd_addr(rd_addr[gi]),
            .pop_en(pop_en[gi]), .shift_en(shift_en[gi]), .hold_en(hold_en[gi]),
            .mult_en(mult_en[gi]), .mag_en(mag_en[gi]),
            .wr_en(wr_en[gi]), .wr_addr(wr_addr[gi]), .get_next(get_next[gi])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    function automatic int rows_of(input int inst);
        return (inst != 0) ? IMG_H / 2 : IMG_H;
    endfunction

    function automatic int step_of(input int inst);
        return (inst != 0) ? 2 : 1;
    endfunction

    // First processed word that starts a line at or beyond the prefetch line.
    function automatic int gn_word(input int inst);
        int n;
        n = WPL * rows_of(inst);
        for (int k = 0; k < n; k++) begin
            if ((k % WPL) == 0 && (k / WPL) * step_of(inst) >= IMG_H - PF)
                return k;
        end
        return -1;
    endfunction

    // {busy, done, rd, pop, shift, hold, mult, mag, wr, get_next}
    function automatic logic [9:0] exp_vec(input int inst, input int t);
        int n, k, p;
        logic [9:0] v;
        n = WPL * rows_of(inst);
        v = '0;
        if (t >= 1 && t <= n * PH) begin
            k = (t - 1) / PH;
            p = (t - 1) % PH;
            v[9] = 1'b1;
            v[7] = (p == 0);
            v[6] = (p == 2);
            v[5] = (p == 3);
            v[4] = (p == 4);
            v[3] = (p == 4);
            v[2] = (p == 5);
            v[1] = (p == 6) && (k >= PRIME);
            v[0] = (p == 0) && (k == gn_word(inst));
        end else if (t > n * PH && t <= n * PH + PL) begin
            v[9] = 1'b1;
        end else if (t == n * PH + PL + 1) begin
            v[8] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [9:0] act_vec(input int i);
        return {busy[i], done[i], rd_en[i], pop_en[i], shift_en[i], hold_en[i],
                mult_en[i], mag_en[i], wr_en[i], get_next[i]};
    endfunction

    function automatic int done_cycle(input int inst);
        return WPL * rows_of(inst) * PH + PL + 1;
    endfunction

    // ---------------- drivers / checkers ----------------
    task automatic kick(input int inst, input logic [19:0] rb, input logic [19:0] wb);
        @(negedge clk);
        rd_base[inst] = rb;
        wr_base[inst] = wb;
        start[inst]   = 1'b1;
    endtask

    // Called in cycle 0 (start already high); checks cycles 1..limit.
    task automatic check_frame(input int inst, input logic [19:0] rb, input logic [19:0] wb,
                               input bit hold, input int pulse_t, input int limit);
        int n, k, nrd, nwr, nwant;
        logic [9:0] ev, av;
        logic [19:0] ea;
        n   = WPL * rows_of(inst);
        nrd = 0;
        nwr = 0;
        for (int t = 1; t <= limit; t++) begin
            @(negedge clk);
            ev = exp_vec(inst, t);
            av = act_vec(inst);
            total++;
            if (av !== ev) begin
                bad++;
                $display("FAIL strobes inst=%0d t=%0d got=%b want=%b", inst, t, av, ev);
            end
            k = (t - 1) / PH;
            if (ev[7]) begin
                ea = rb + 20'(((k / WPL) * step_of(inst)) * WPL + (k % WPL));
                total++;
                if (rd_addr[inst] !== ea) begin
                    bad++;
                    $display("FAIL rd_addr inst=%0d t=%0d got=%h want=%h", inst, t, rd_addr[inst], ea);
                end
            end
            if (ev[1]) begin
                ea = wb + 20'(k - PRIME);
                total++;
                if (wr_addr[inst] !== ea) begin
                    bad++;
                    $display("FAIL wr_addr inst=%0d t=%0d got=%h want=%h", inst, t, wr_addr[inst], ea);
                end
            end
            if (av[7]) nrd++;
            if (av[1]) nwr++;
            if (t == 1 && !hold) start[inst] = 1'b0;
            if (t == 2) begin
                // bases must have been captured at start
                rd_base[inst] = 20'($urandom);
                wr_base[inst] = 20'($urandom);
            end
            if (t == pulse_t) start[inst] = 1'b1;
            if (t == pulse_t + 1) start[inst] = 1'b0;
        end
        if (limit >= done_cycle(inst)) begin
            nwant = (n > PRIME) ? n - PRIME : 0;
            total++;
            if (nrd != n) begin
                bad++;
                $display("FAIL read_count inst=%0d got=%0d want=%0d", inst, nrd, n);
            end
            total++;
            if (nwr != nwant) begin
                bad++;
                $display("FAIL write_count inst=%0d got=%0d want=%0d", inst, nwr, nwant);
            end
        end
        $display("frame inst=%0d rd_base=%h wr_base=%h cycles=%0d reads=%0d writes=%0d",
                 inst, rb, wb, limit, nrd, nwr);
    endtask

    task automatic check_quiet(input int inst, input string tag);
        total++;
        if (act_vec(inst) !== 10'b0 || rd_addr[inst] !== 20'h0 || wr_addr[inst] !== 20'h0) begin
            bad++;
            $display("FAIL %s inst=%0d got=%b rd=%h wr=%h want=all zero",
                     tag, inst, act_vec(inst), rd_addr[inst], wr_addr[inst]);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check_quiet(0, "reset_state");
        check_quiet(1, "reset_state");
        reset = 1'b0;
        @(negedge clk);
        check_quiet(0, "idle_after_reset");
        check_quiet(1, "idle_after_reset");
    endtask

    task automatic test_basic_frame();
        kick(0, 20'h00100, 20'h00400);
        check_frame(0, 20'h00100, 20'h00400, 1'b0, -10, done_cycle(0) + 3);
    endtask

    task automatic test_skip_mode();
        kick(1, 20'h00000, 20'h00800);
        check_frame(1, 20'h00000, 20'h00800, 1'b0, -10, done_cycle(1) + 3);
    endtask

    task automatic test_ignored_start();
        kick(0, 20'h02000, 20'h03000);
        check_frame(0, 20'h02000, 20'h03000, 1'b0, 40, done_cycle(0) + 3);
    endtask

    task automatic test_mid_frame_reset();
        kick(0, 20'h00100, 20'h00400);
        check_frame(0, 20'h00100, 20'h00400, 1'b0, -10, 50);
        reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_quiet(0, "mid_reset");
        end
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_quiet(0, "post_reset_idle");
        end
        kick(0, 20'h00140, 20'h00500);
        check_frame(0, 20'h00140, 20'h00500, 1'b0, -10, done_cycle(0) + 3);
    endtask

    task automatic test_addr_wrap();
        kick(0, 20'hFFFFC, 20'hFFFF0);
        check_frame(0, 20'hFFFFC, 20'hFFFF0, 1'b0, -10, done_cycle(0) + 3);
    endtask

    task automatic test_back_to_back();
        kick(1, 20'h00300, 20'h00600);
        check_frame(1, 20'h00300, 20'h00600, 1'b1, -10, done_cycle(1));
        @(negedge clk);
        // IDLE for one cycle while start is still high
        total++;
        if (act_vec(1) !== 10'b0) begin
            bad++;
            $display("FAIL b2b_idle got=%b want=%b", act_vec(1), 10'b0);
        end
        rd_base[1] = 20'h00700;
        wr_base[1] = 20'h00900;
        check_frame(1, 20'h00700, 20'h00900, 1'b0, -10, done_cycle(1) + 3);
    endtask

    task automatic test_random();
        int inst;
        logic [19:0] rb, wb;
        for (int r = 0; r < 4; r++) begin
            inst = r % 2;
            rb = 20'($urandom);
            wb = 20'($urandom);
            repeat ($urandom_range(0, 5)) @(negedge clk);
            kick(inst, rb, wb);
            check_frame(inst, rb, wb, 1'b0, -10, done_cycle(inst) + 3);
        end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        reset   = 1'b1;
        start   = '0;
        rd_base = '0;
        wr_base = '0;
        test_reset();
        test_basic_frame();
        test_skip_mode();
        test_ignored_start();
        test_mid_frame_reset();
        test_addr_wrap();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
